command_reader_ctrl: RTL

Sequencing FSM for the command reader datapath. Accepts command bytes from the UART RX path and holds the command stable for the datapath, which derives the channel select from it. Drives the word-select and timer-select codes, waits for the channel's peak value or the slow-domain timeout, then hands one response byte to the UART TX path. One transaction is in flight at a time.

---
 rtl/command_reader_ctrl_pkg.sv | 34 +++
 rtl/command_reader_ctrl_if.sv | 25 ++
 rtl/command_reader_ctrl_wait_counter.sv | 25 ++
 rtl/command_reader_ctrl.sv | 123 ++++++++++++
 4 files changed

// File: rtl/command_reader_ctrl_pkg.sv
// rtl/command_reader_ctrl_pkg.sv - select codes, opcodes, states and response bytes for command_reader_ctrl
package command_reader_pkg;

    localparam logic [1:0] WORD_HOLD  = 2'b00;
    localparam logic [1:0] WORD_MAX   = 2'b01;
    localparam logic [1:0] WORD_TRUE  = 2'b10;
    localparam logic [1:0] WORD_FALSE = 2'b11;

    localparam logic [1:0] TMR_HOLD   = 2'b00;
    localparam logic [1:0] TMR_COUNT  = 2'b01;
    localparam logic [1:0] TMR_CLEAR  = 2'b10;

    localparam logic [2:0] OP_PING     = 3'b000;
    localparam logic [2:0] OP_READ_MAX = 3'b001;
    localparam logic [2:0] OP_CLR_PEAK = 3'b010;

    localparam logic [7:0] RESP_TRUE  = 8'h30;
    localparam logic [7:0] RESP_FALSE = 8'h31;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE       = 3'd0;
    localparam state_t ST_DECODE     = 3'd1;
    localparam state_t ST_CLR_TIMER  = 3'd2;
    localparam state_t ST_WAIT_DATA  = 3'd3;
    localparam state_t ST_LOAD_MAX   = 3'd4;
    localparam state_t ST_LOAD_TRUE  = 3'd5;
    localparam state_t ST_LOAD_FALSE = 3'd6;
    localparam state_t ST_SEND       = 3'd7;

    function automatic logic [2:0] opcode_of(input logic [7:0] cmd);
        return cmd[7:5];
    endfunction

endpackage

// File: rtl/command_reader_ctrl_if.sv
// rtl/command_reader_ctrl_if.sv - handshake and select signals between the sequencer and its datapath
interface command_reader_ctrl_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       max_valid;
    logic       timeout;
    logic       tx_ready;
    logic [7:0] cmd;
    logic [1:0] word_sel;
    logic [1:0] timer_sel;
    logic       peak_req;
    logic       peak_clr;
    logic       tx_start;
    logic       busy;

    modport master (
        input  rx_valid, rx_data, max_valid, timeout, tx_ready,
        output cmd, word_sel, timer_sel, peak_req, peak_clr, tx_start, busy
    );

    modport slave (
        output rx_valid, rx_data, max_valid, timeout, tx_ready,
        input  cmd, word_sel, timer_sel, peak_req, peak_clr, tx_start, busy
    );
endinterface

// File: rtl/command_reader_ctrl_wait_counter.sv
// rtl/command_reader_ctrl_wait_counter.sv - loadable saturating down-counter with zero flag
module cmd_wait_counter #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         reset_b,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);
    logic [W-1:0] count;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);
endmodule

// File: rtl/command_reader_ctrl.sv
// rtl/command_reader_ctrl.sv - command reader sequencing FSM; optional BUSY_NAK_EN answers bytes dropped while busy with 0x31
module command_reader_ctrl
    import command_reader_pkg::*;
#(
    parameter int CLR_HOLD_CYCLES = 32,
    parameter int TIMEOUT_GUARD   = 16
) (
    input  logic                 clk,
    input  logic                 reset_b,
    command_reader_ctrl_if.master bus
);
    localparam int CNT_MAX = (CLR_HOLD_CYCLES > TIMEOUT_GUARD) ? CLR_HOLD_CYCLES : TIMEOUT_GUARD;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(CLR_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(TIMEOUT_GUARD);

    state_t           state, state_nxt;
    logic [7:0]       cmd_q;
    logic [2:0]       opcode;
    logic             nak_pend;
    logic             cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0] cnt_val;

    assign opcode = opcode_of(cmd_q);

    cmd_wait_counter #(.W(CNT_W)) u_wait_counter (
        .clk      (clk),
        .reset_b  (reset_b),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_nxt = state;
        cnt_load  = 1'b0;
        cnt_val   = HOLD_LOAD;
        case (state)
            ST_IDLE: begin
                if (nak_pend)          state_nxt = ST_LOAD_FALSE;
                else if (bus.rx_valid) state_nxt = ST_DECODE;
            end
            ST_DECODE: begin
                case (opcode)
                    OP_READ_MAX: begin
                        state_nxt = ST_CLR_TIMER;
                        cnt_load  = 1'b1;
                    end
                    OP_PING, OP_CLR_PEAK: state_nxt = ST_LOAD_TRUE;
                    default:              state_nxt = ST_LOAD_FALSE;
                endcase
            end
            ST_CLR_TIMER: begin
                // Hand the counter over to the timeout guard as the hold ends
                if (cnt_zero) begin
                    state_nxt = ST_WAIT_DATA;
                    cnt_load  = 1'b1;
                    cnt_val   = GUARD_LOAD;
                end
            end
            ST_WAIT_DATA: begin
                if (bus.max_valid)                 state_nxt = ST_LOAD_MAX;
                else if (bus.timeout && cnt_zero)  state_nxt = ST_LOAD_FALSE;
            end
            ST_LOAD_MAX, ST_LOAD_TRUE, ST_LOAD_FALSE: state_nxt = ST_SEND;
            ST_SEND: begin
                if (bus.tx_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign cnt_dec = (state == ST_CLR_TIMER) || (state == ST_WAIT_DATA);

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state <= ST_IDLE;
            cmd_q <= 8'h00;
        end else begin
            state <= state_nxt;
            if ((state == ST_IDLE) && !nak_pend && bus.rx_valid) begin
                cmd_q <= bus.rx_data;
            end
        end
    end

`ifdef BUSY_NAK_EN
    logic pending_nak;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            pending_nak <= 1'b0;
        end else if ((state == ST_IDLE) && pending_nak) begin
            pending_nak <= 1'b0;
        end else if (bus.rx_valid && (state != ST_IDLE)) begin
            pending_nak <= 1'b1;
        end
    end

    assign nak_pend = pending_nak;
`else
    assign nak_pend = 1'b0;
`endif

    always_comb begin
        case (state)
            ST_LOAD_MAX:   bus.word_sel = WORD_MAX;
            ST_LOAD_TRUE:  bus.word_sel = WORD_TRUE;
            ST_LOAD_FALSE: bus.word_sel = WORD_FALSE;
            default:       bus.word_sel = WORD_HOLD;
        endcase
    end

    // Timer only counts while waiting; everywhere else it is held cleared
    assign bus.timer_sel = (state == ST_WAIT_DATA) ? TMR_COUNT : TMR_CLEAR;
    assign bus.peak_req  = (state == ST_CLR_TIMER) || (state == ST_WAIT_DATA);
    assign bus.peak_clr  = (state == ST_DECODE) && (opcode == OP_CLR_PEAK);
    assign bus.tx_start  = (state == ST_SEND) && bus.tx_ready;
    assign bus.busy      = (state != ST_IDLE);
    assign bus.cmd       = cmd_q;

endmodule
